// File: rtl/sd_cmd_sequencer.sv
// SD command sequencer: arbitrates register/DMA command requests round-robin,
// issues one command at a time to the CMD block and reports completion or timeout.
module sd_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_host,
    input  logic        reset_host,
    input  logic        req_reg,
    input  logic [5:0]  idx_reg,
    input  logic [31:0] arg_reg,
    output logic        grant_reg,
    input  logic        req_dma,
    input  logic [5:0]  idx_dma,
    input  logic [31:0] arg_dma,
    output logic        grant_dma,
    output logic        new_command,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_argument,
    input  logic        cmd_complete,
    input  logic        cmd_index_error,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic        done_owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_IDX_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    state_t      state_reg;
    logic        owner_reg;       // 0 register side, 1 DMA side
    logic        last_owner_reg;
    logic [15:0] count_reg;
    logic        pick_dma;

    // DMA wins when it is the only requester, or on a tie when the register side was served last.
    always_comb begin
        pick_dma = req_dma && (!req_reg || !last_owner_reg);
    end

    always_ff @(posedge clk_host) begin
        if (reset_host) begin
            state_reg      <= S_IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            count_reg      <= '0;
            grant_reg      <= 1'b0;
            grant_dma      <= 1'b0;
            new_command    <= 1'b0;
            cmd_index      <= '0;
            cmd_argument   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            status         <= ST_OK;
            done_owner     <= 1'b0;
        end else begin
            grant_reg   <= 1'b0;
            grant_dma   <= 1'b0;
            new_command <= 1'b0;
            done        <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req_reg || req_dma) begin
                        state_reg      <= S_ISSUE;
                        busy           <= 1'b1;
                        owner_reg      <= pick_dma;
                        last_owner_reg <= pick_dma;
                        cmd_index      <= pick_dma ? idx_dma : idx_reg;
                        cmd_argument   <= pick_dma ? arg_dma : arg_reg;
                        grant_reg      <= !pick_dma;
                        grant_dma      <= pick_dma;
                        new_command    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_reg <= S_WAIT;
                    count_reg <= '0;
                end
                S_WAIT: begin
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (cmd_complete) begin
                        state_reg  <= S_DONE;
                        done       <= 1'b1;
                        done_owner <= owner_reg;
                        status     <= cmd_index_error ? ST_IDX_ERR : ST_OK;
                    end else if (count_reg == LAST_COUNT) begin
                        state_reg  <= S_DONE;
                        done       <= 1'b1;
                        done_owner <= owner_reg;
                        status     <= ST_TIMEOUT;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
